// File: rtl/led_pattern_pkg.sv
// Shared mode encodings and FSM state type for the LED pattern sequencer.
package led_pattern_pkg;

   localparam logic [1:0] MODE_ROT_L = 2'b00;
   localparam logic [1:0] MODE_ROT_R = 2'b01;
   localparam logic [1:0] MODE_PP    = 2'b10;
   localparam logic [1:0] MODE_BLINK = 2'b11;

   typedef enum logic [2:0] {
      ROT_L   = 3'd0,
      ROT_R   = 3'd1,
      PP_UP   = 3'd2,
      PP_DN   = 3'd3,
      BLK_ON  = 3'd4,
      BLK_OFF = 3'd5
   } state_e;

   function automatic state_e start_state(input logic [1:0] mode);
      case (mode)
         MODE_ROT_R: return ROT_R;
         MODE_PP:    return PP_UP;
         MODE_BLINK: return BLK_ON;
         default:    return ROT_L;
      endcase
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate counter: cnt runs 0..TICK_DIV-1, otick flags the last count unless held.
module led_tick_gen #(
   parameter int TICK_DIV = 12000000
) (
   input  logic iclk,
   input  logic irst,
   input  logic ihold,
   input  logic iclr,
   output logic otick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   // Clear beats hold so a mode change always restarts a full step period.
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         cnt <= '0;
      end else if (iclr) begin
         cnt <= '0;
      end else if (!ihold) begin
         cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
      end
   end

   assign otick = (cnt == CNT_MAX) && !ihold;

endmodule

// File: rtl/led_pattern_fsm.sv
// LED pattern sequencer: rotate left/right, ping-pong and blink, one step per tick.
// Define LED_ACTIVE_LOW_EN to drive owvled inverted for boards with low-lit LEDs.
//
//   state   | meaning
//   ROT_L   | single lit bit moving toward MSB, wraps to bit0
//   ROT_R   | single lit bit moving toward bit0, wraps to MSB
//   PP_UP   | ping-pong, moving toward MSB
//   PP_DN   | ping-pong, moving toward bit0
//   BLK_ON  | all LEDs on
//   BLK_OFF | all LEDs off
module led_pattern_fsm
   import led_pattern_pkg::*;
#(
   parameter int LED_NUM  = 8,
   parameter int TICK_DIV = 12000000
) (
   input  logic               iclk,
   input  logic               irst,
   input  logic [1:0]         imode,
   input  logic               ihold,
   output logic [LED_NUM-1:0] owvled,
   output logic               otick
);

   logic [1:0]         mode_q;
   logic               mode_chg;
   state_e             state, state_n;
   logic [LED_NUM-1:0] pat, pat_n;
   logic [LED_NUM-1:0] start_pat;

   assign mode_chg = (imode != mode_q);

   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .iclk  (iclk),
      .irst  (irst),
      .ihold (ihold),
      .iclr  (mode_chg),
      .otick (otick)
   );

   always_comb begin
      case (imode)
         MODE_ROT_R: start_pat = {1'b1, {(LED_NUM-1){1'b0}}};
         MODE_BLINK: start_pat = '1;
         default:    start_pat = LED_NUM'(1);
      endcase
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         mode_q <= MODE_ROT_L;
         state  <= ROT_L;
         pat    <= LED_NUM'(1);
      end else begin
         mode_q <= imode;
         state  <= state_n;
         pat    <= pat_n;
      end
   end

   // otick is already gated by ihold, so a held step never reaches here.
   always_comb begin
      state_n = state;
      pat_n   = pat;
      if (mode_chg) begin
         state_n = start_state(imode);
         pat_n   = start_pat;
      end else if (otick) begin
         case (state)
            ROT_L: pat_n = {pat[LED_NUM-2:0], pat[LED_NUM-1]};
            ROT_R: pat_n = {pat[0], pat[LED_NUM-1:1]};
            PP_UP: begin
               pat_n = pat << 1;
               if (pat[LED_NUM-2]) state_n = PP_DN;
            end
            PP_DN: begin
               pat_n = pat >> 1;
               if (pat[1]) state_n = PP_UP;
            end
            BLK_ON: begin
               pat_n   = '0;
               state_n = BLK_OFF;
            end
            BLK_OFF: begin
               pat_n   = '1;
               state_n = BLK_ON;
            end
            default: begin
               pat_n   = LED_NUM'(1);
               state_n = ROT_L;
            end
         endcase
      end
   end

`ifdef LED_ACTIVE_LOW_EN
   assign owvled = ~pat;
`else
   assign owvled = pat;
`endif

endmodule

// File: tb/tb_led_pattern_fsm.sv
// Self-checking bench for led_pattern_fsm (LED_NUM=8, TICK_DIV=4): vector table,
// corner-case sequences and a randomized run against a step-index reference model.
module tb_led_pattern_fsm;

   localparam int N  = 8;
   localparam int TD = 4;

   logic         iclk = 1'b0;
   logic         irst = 1'b0;
   logic [1:0]   imode = 2'b00;
   logic         ihold = 1'b0;
   logic [N-1:0] owvled;
   logic         otick;

   always #5 iclk = ~iclk;

   led_pattern_fsm #(
      .LED_NUM  (N),
      .TICK_DIV (TD)
   ) dut (
      .iclk   (iclk),
      .irst   (irst),
      .imode  (imode),
      .ihold  (ihold),
      .owvled (owvled),
      .otick  (otick)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: current mode, steps taken since mode entry, count within step.
   int m_mode;
   int m_k;
   int m_cnt;

   typedef struct {
      logic [1:0] mode;
      logic       hold;
      logic [7:0] led;
      logic       tick;
   } vec_t;

   vec_t tbl[25];

   function automatic logic [N-1:0] phys(input logic [N-1:0] p);
`ifdef LED_ACTIVE_LOW_EN
      return ~p;
`else
      return p;
`endif
   endfunction

   function automatic logic [N-1:0] model_pat();
      logic [N-1:0] one;
      int p;
      int idx;
      one = 1;
      case (m_mode)
         0: return one << (m_k % N);
         1: return one << (N - 1 - (m_k % N));
         2: begin
            p   = m_k % (2*N - 2);
            idx = (p < N) ? p : (2*N - 2 - p);
            return one << idx;
         end
         default: return ((m_k % 2) == 0) ? {N{1'b1}} : {N{1'b0}};
      endcase
   endfunction

   function automatic logic model_tick();
      return (m_cnt == TD - 1) && !ihold;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_k    = 0;
      m_cnt  = 0;
   endtask

   task automatic apply(input logic [1:0] m, input logic h);
      @(negedge iclk);
      imode = m;
      ihold = h;
      #1;
   endtask

   task automatic step_edge();
      @(posedge iclk);
      if (int'(imode) != m_mode) begin
         m_mode = int'(imode);
         m_k    = 0;
         m_cnt  = 0;
      end else if (!ihold) begin
         if (m_cnt == TD - 1) begin
            m_cnt = 0;
            m_k++;
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic cyc(input logic [1:0] m, input logic h);
      apply(m, h);
      check("model_led", owvled, phys(model_pat()));
      check("model_tick", otick, model_tick());
      step_edge();
   endtask

   // Reset is asserted and released between clock edges.
   task automatic do_reset(input logic [1:0] m);
      @(posedge iclk);
      #2;
      irst  = 1'b1;
      imode = m;
      ihold = 1'b0;
      #1;
      check("reset_led", owvled, phys(8'h01));
      check("reset_tick", otick, 1'b0);
      model_reset();
      @(posedge iclk);
      #1;
      check("reset_led_held", owvled, phys(8'h01));
      #1;
      irst = 1'b0;
   endtask

   initial begin
      logic [1:0] rm;
      logic       rh;

      tbl[0]  = '{2'b00, 1'b0, 8'h01, 1'b0};
      tbl[1]  = '{2'b00, 1'b0, 8'h01, 1'b0};
      tbl[2]  = '{2'b00, 1'b0, 8'h01, 1'b0};
      tbl[3]  = '{2'b00, 1'b0, 8'h01, 1'b1};
      tbl[4]  = '{2'b00, 1'b0, 8'h02, 1'b0};
      tbl[5]  = '{2'b00, 1'b0, 8'h02, 1'b0};
      tbl[6]  = '{2'b00, 1'b0, 8'h02, 1'b0};
      tbl[7]  = '{2'b00, 1'b0, 8'h02, 1'b1};
      tbl[8]  = '{2'b00, 1'b0, 8'h04, 1'b0};
      tbl[9]  = '{2'b00, 1'b0, 8'h04, 1'b0};
      tbl[10] = '{2'b00, 1'b0, 8'h04, 1'b0};
      tbl[11] = '{2'b00, 1'b0, 8'h04, 1'b1};
      tbl[12] = '{2'b11, 1'b0, 8'h08, 1'b0};
      tbl[13] = '{2'b11, 1'b0, 8'hFF, 1'b0};
      tbl[14] = '{2'b11, 1'b0, 8'hFF, 1'b0};
      tbl[15] = '{2'b11, 1'b0, 8'hFF, 1'b0};
      tbl[16] = '{2'b11, 1'b0, 8'hFF, 1'b1};
      tbl[17] = '{2'b11, 1'b0, 8'h00, 1'b0};
      tbl[18] = '{2'b11, 1'b0, 8'h00, 1'b0};
      tbl[19] = '{2'b11, 1'b0, 8'h00, 1'b0};
      tbl[20] = '{2'b11, 1'b0, 8'h00, 1'b1};
      tbl[21] = '{2'b11, 1'b0, 8'hFF, 1'b0};
      tbl[22] = '{2'b11, 1'b0, 8'hFF, 1'b0};
      tbl[23] = '{2'b11, 1'b0, 8'hFF, 1'b0};
      tbl[24] = '{2'b11, 1'b0, 8'hFF, 1'b1};

      // Vector table: rotate-left start, then switch into blink.
      do_reset(2'b00);
      for (int i = 0; i < 25; i++) begin
         apply(tbl[i].mode, tbl[i].hold);
         check($sformatf("tbl%0d_led", i), owvled, phys(tbl[i].led));
         check($sformatf("tbl%0d_tick", i), otick, tbl[i].tick);
         step_edge();
      end

      // Mode switch at led=08, cnt=2: reload to 80 next cycle, 40 four cycles later.
      do_reset(2'b00);
      for (int i = 0; i < 14; i++) cyc(2'b00, 1'b0);
      apply(2'b01, 1'b0);
      check("sw_before_led", owvled, phys(8'h08));
      check("sw_before_tick", otick, 1'b0);
      step_edge();
      apply(2'b01, 1'b0);
      check("sw_reload_led", owvled, phys(8'h80));
      check("sw_reload_tick", otick, 1'b0);
      step_edge();
      cyc(2'b01, 1'b0);
      cyc(2'b01, 1'b0);
      apply(2'b01, 1'b0);
      check("sw_last_led", owvled, phys(8'h80));
      check("sw_last_tick", otick, 1'b1);
      step_edge();
      apply(2'b01, 1'b0);
      check("sw_step_led", owvled, phys(8'h40));
      step_edge();

      // Hold for 10 cycles at cnt=1, then the step lands 3 cycles after release.
      do_reset(2'b00);
      cyc(2'b00, 1'b0);
      for (int i = 0; i < 10; i++) begin
         apply(2'b00, 1'b1);
         check("hold_led", owvled, phys(8'h01));
         check("hold_tick", otick, 1'b0);
         step_edge();
      end
      for (int i = 0; i < 2; i++) begin
         apply(2'b00, 1'b0);
         check("rel_led", owvled, phys(8'h01));
         check("rel_tick", otick, 1'b0);
         step_edge();
      end
      apply(2'b00, 1'b0);
      check("rel_last_tick", otick, 1'b1);
      step_edge();
      apply(2'b00, 1'b0);
      check("rel_step_led", owvled, phys(8'h02));
      step_edge();

      // Reset mid-step discards the partial count.
      for (int i = 0; i < 6; i++) cyc(2'b01, 1'b0);
      do_reset(2'b00);
      for (int i = 0; i < 4; i++) begin
         apply(2'b00, 1'b0);
         check("post_rst_led", owvled, phys(8'h01));
         step_edge();
      end
      apply(2'b00, 1'b0);
      check("post_rst_step", owvled, phys(8'h02));
      step_edge();

      // Non-zero mode held through reset reloads on the first edge.
      do_reset(2'b01);
      apply(2'b01, 1'b0);
      check("rst_m1_led0", owvled, phys(8'h01));
      step_edge();
      apply(2'b01, 1'b0);
      check("rst_m1_led1", owvled, phys(8'h80));
      step_edge();

      // Full ping-pong periods and a blink run against the model.
      for (int i = 0; i < 64; i++) cyc(2'b10, 1'b0);
      for (int i = 0; i < 40; i++) cyc(2'b01, 1'b0);
      for (int i = 0; i < 12; i++) cyc(2'b11, 1'b0);

      // Randomized modes and holds.
      do_reset(2'($urandom_range(0, 3)));
      rm = 2'($urandom_range(0, 3));
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 19) == 0) rm = 2'($urandom_range(0, 3));
         rh = ($urandom_range(0, 5) == 0);
         cyc(rm, rh);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
